dino_button_conditioner: RTL and testbench

Conditions the single player button before it reaches the system's `button_export` input. It synchronizes the raw, already-inverted (active-high) key, debounces press and release, and produces a clean level, one-cycle press/release/long-press events, and a wrapping press counter. It sits between the board pin inversion and the system core, in the same clock domain as the core.

---
 rtl/dino_button_conditioner.sv | 131 +++++++++++++
 tb/tb_dino_button_conditioner.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dino_button_conditioner.sv
// dino_button_conditioner
// Cleans up the single player button before it reaches the system core.
// The raw active-high key passes through a two-flop synchronizer and then a
// four-state debounce machine. The machine produces a debounced level, one-cycle
// press, release and long-press events, and a wrapping 8-bit press counter.
// Every output is a register, so downstream logic sees glitch-free signals.
module dino_button_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 25000000,
    parameter int CNT_W             = 25
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       button_raw,
    output logic       button_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press,
    output logic       long_held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             sync1_reg;
    logic             sync_reg;
    state_t           state_reg;
    logic [CNT_W-1:0] db_cnt_reg;
    logic [CNT_W-1:0] hold_cnt_reg;
    logic             long_fired_reg;

    // Two-flop synchronizer; only sync_reg is allowed to reach the state machine.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_reg <= 1'b0;
            sync_reg  <= 1'b0;
        end else begin
            sync1_reg <= button_raw;
            sync_reg  <= sync1_reg;
        end
    end

    // Debounce state machine, hold timer and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            db_cnt_reg     <= '0;
            hold_cnt_reg   <= '0;
            long_fired_reg <= 1'b0;
            button_level   <= 1'b0;
            press_pulse    <= 1'b0;
            release_pulse  <= 1'b0;
            long_press     <= 1'b0;
            long_held      <= 1'b0;
            press_count    <= 8'd0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;

            // The hold timer keeps running through a release bounce, so a
            // bouncy release does not restart the long-press measurement.
            if (state_reg == PRESSED || state_reg == RELEASE_WAIT) begin
                if (hold_cnt_reg != LONG_LAST) begin
                    hold_cnt_reg <= hold_cnt_reg + CNT_ONE;
                end
                if (hold_cnt_reg == LONG_LAST && !long_fired_reg) begin
                    long_press     <= 1'b1;
                    long_held      <= 1'b1;
                    long_fired_reg <= 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (sync_reg) begin
                        state_reg  <= PRESS_WAIT;
                        db_cnt_reg <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_reg) begin
                        state_reg <= IDLE;
                    end else if (db_cnt_reg == DB_LAST) begin
                        state_reg      <= PRESSED;
                        press_pulse    <= 1'b1;
                        button_level   <= 1'b1;
                        press_count    <= press_count + 8'd1;
                        hold_cnt_reg   <= '0;
                        long_fired_reg <= 1'b0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync_reg) begin
                        state_reg  <= RELEASE_WAIT;
                        db_cnt_reg <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync_reg) begin
                        state_reg <= PRESSED;
                    end else if (db_cnt_reg == DB_LAST) begin
                        // Later assignments win over the long-press block above.
                        state_reg      <= IDLE;
                        release_pulse  <= 1'b1;
                        button_level   <= 1'b0;
                        long_held      <= 1'b0;
                        long_fired_reg <= 1'b0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dino_button_conditioner.sv
// tb_dino_button_conditioner
// Scoreboard bench: each stimulus step pushes the events it must produce,
// with the edge number and press count expected at that event. The monitor
// pops and compares every event the DUT emits.
module tb_dino_button_conditioner;

    localparam logic [2:0] EV_PRESS   = 3'b001;
    localparam logic [2:0] EV_RELEASE = 3'b010;
    localparam logic [2:0] EV_LONG    = 3'b100;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       button_raw = 1'b0;
    logic       button_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press;
    logic       long_held;
    logic [7:0] press_count;

    typedef struct {
        int         edge_no;
        logic [2:0] kind;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   edge_n   = 0;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    dino_button_conditioner #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(10),
        .CNT_W            (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .button_raw   (button_raw),
        .button_level (button_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .long_held    (long_held),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic push_ev(input int edge_no, input logic [2:0] kind, input logic [7:0] cnt);
        exp_t e;
        e.edge_no = edge_no;
        e.kind    = kind;
        e.cnt     = cnt;
        sb_q.push_back(e);
    endtask

    // Advance one edge, then sample outputs 1 time unit after it.
    task automatic tick();
        logic [2:0] ev;
        exp_t       e;
        @(posedge clk);
        edge_n++;
        #1;
        ev = {long_press, release_pulse, press_pulse};
        if (ev != 3'b000) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_event", 32'(ev), 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("edge %0d: event %b count %0d (expected %b at edge %0d count %0d)",
                         edge_n, ev, press_count, e.kind, e.edge_no, e.cnt);
                check_eq("ev_kind", 32'(ev), 32'(e.kind));
                check_eq("ev_edge", edge_n, e.edge_no);
                check_eq("ev_count", 32'(press_count), 32'(e.cnt));
            end
        end
    endtask

    task automatic drive(input logic v, input int n);
        button_raw = v;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_level"}, 32'(button_level), 32'd0);
        check_eq({tag, "_press"}, 32'(press_pulse), 32'd0);
        check_eq({tag, "_release"}, 32'(release_pulse), 32'd0);
        check_eq({tag, "_long"}, 32'(long_press), 32'd0);
        check_eq({tag, "_held"}, 32'(long_held), 32'd0);
        check_eq({tag, "_count"}, 32'(press_count), 32'd0);
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        for (int i = 0; i < n; i++) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int e0;
        int e1;

        // Reset state
        do_reset(3);
        check_all_zero("reset");

        // Bounce rejection: 3 high / 2 low, five times
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3);
            drive(1'b0, 2);
        end
        drive(1'b0, 8);
        check_eq("bounce_level", 32'(button_level), 32'd0);
        check_eq("bounce_count", 32'(press_count), 32'd0);

        // Clean press held 20 cycles
        e0 = edge_n + 1;
        push_ev(e0 + 6, EV_PRESS, 8'd1);
        push_ev(e0 + 16, EV_LONG, 8'd1);
        push_ev(e0 + 26, EV_RELEASE, 8'd1);
        drive(1'b1, 20);
        check_eq("clean_level_held", 32'(button_level), 32'd1);
        check_eq("clean_long_held", 32'(long_held), 32'd1);
        drive(1'b0, 10);
        check_eq("clean_level_rel", 32'(button_level), 32'd0);
        check_eq("clean_held_rel", 32'(long_held), 32'd0);
        check_eq("clean_count", 32'(press_count), 32'd1);

        // Release bounce: 2-cycle dropout after acceptance
        e0 = edge_n + 1;
        push_ev(e0 + 6, EV_PRESS, 8'd2);
        push_ev(e0 + 16, EV_LONG, 8'd2);
        push_ev(e0 + 28, EV_RELEASE, 8'd2);
        drive(1'b1, 8);
        drive(1'b0, 2);
        drive(1'b1, 4);
        check_eq("relbounce_level", 32'(button_level), 32'd1);
        drive(1'b1, 8);
        check_eq("relbounce_long_held", 32'(long_held), 32'd1);
        drive(1'b0, 10);
        check_eq("relbounce_level_rel", 32'(button_level), 32'd0);

        // Short press: no long press
        e0 = edge_n + 1;
        push_ev(e0 + 6, EV_PRESS, 8'd3);
        push_ev(e0 + 14, EV_RELEASE, 8'd3);
        drive(1'b1, 8);
        drive(1'b0, 10);
        check_eq("short_long_held", 32'(long_held), 32'd0);
        check_eq("short_count", 32'(press_count), 32'd3);

        // Counter wrap: 257 presses from zero
        do_reset(1);
        check_eq("wrap_start_count", 32'(press_count), 32'd0);
        for (int i = 1; i <= 257; i++) begin
            e0 = edge_n + 1;
            push_ev(e0 + 6, EV_PRESS, 8'(i % 256));
            push_ev(e0 + 12, EV_RELEASE, 8'(i % 256));
            drive(1'b1, 6);
            drive(1'b0, 8);
        end
        check_eq("wrap_count", 32'(press_count), 32'd1);

        // Reset while PRESSED with the button still held
        e0 = edge_n + 1;
        push_ev(e0 + 6, EV_PRESS, 8'd2);
        drive(1'b1, 8);
        check_eq("midreset_level_before", 32'(button_level), 32'd1);
        do_reset(1);
        check_all_zero("midreset");
        e1 = edge_n + 1;
        push_ev(e1 + 6, EV_PRESS, 8'd1);
        push_ev(e1 + 14, EV_RELEASE, 8'd1);
        drive(1'b1, 8);
        drive(1'b0, 10);
        check_eq("midreset_count", 32'(press_count), 32'd1);

        check_eq("sb_drain", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
